// File: rtl/life_gen_scheduler.sv
// Generation strobe, run/step and edit arbitration for the 16x16 Game-of-Life cell array.
// Optional feature: define LIFE_GEN_LIMIT_EN to add the gen_limit input and halted output.
module life_gen_scheduler #(
  parameter int GRID_W     = 16,
  parameter int GRID_H     = 16,
  parameter int CNT_W      = 32,
  parameter int MIN_PERIOD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_en,
  input  logic             step_req,
  input  logic [CNT_W-1:0] period,
  input  logic             edit_req,
  input  logic [1:0]       edit_op,
  input  logic [3:0]       edit_x,
  input  logic [3:0]       edit_y,
  input  logic             calc_done,
`ifdef LIFE_GEN_LIMIT_EN
  input  logic [15:0]      gen_limit,
  output logic             halted,
`endif
  output logic             calc_start,
  output logic             wr_en,
  output logic [1:0]       wr_op,
  output logic [7:0]       wr_addr,
  output logic             edit_ack,
  output logic             edit_err,
  output logic             overrun,
  output logic             busy,
  output logic [15:0]      gen_count,
  output logic             tick_led
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_EDIT = 2'd2;

  localparam logic [1:0] OP_TOGGLE = 2'd0;

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

  // Control state
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_gen_pend;
  logic             r_edit_pend;

  // One-deep edit buffer
  logic [1:0]       r_buf_op;
  logic [3:0]       r_buf_x;
  logic [3:0]       r_buf_y;

  // Registered outputs
  logic             r_calc_start;
  logic             r_wr_en;
  logic [1:0]       r_wr_op;
  logic [7:0]       r_wr_addr;
  logic             r_edit_ack;
  logic             r_edit_err;
  logic             r_overrun;
  logic [15:0]      r_gen_count;
  logic             r_tick_led;

  // Datapath / decision wires
  logic [CNT_W-1:0] w_eff_period;
  logic [CNT_W-1:0] w_last;
  logic             w_halted;
  logic             w_run_active;
  logic             w_wrap;
  logic             w_step_trig;
  logic             w_trig;
  logic             w_drop;
  logic             w_accept;
  logic             w_go_calc;
  logic             w_go_edit;
  logic             w_calc_end;
  logic [1:0]       w_sel_op;
  logic [3:0]       w_sel_x;
  logic [3:0]       w_sel_y;
  logic             w_is_toggle;
  logic             w_in_range;
  logic [7:0]       w_addr;

  // ---------------------------------------------------------------------------
  // Generation triggers
  // ---------------------------------------------------------------------------
  assign w_eff_period = (period < MIN_P) ? MIN_P : period;
  assign w_last       = w_eff_period - CNT_W'(1);

  assign w_run_active = run_en & ~w_halted;
  // ">=" lets a shortened period take effect at once instead of wrapping the counter.
  assign w_wrap       = w_run_active & (r_cnt >= w_last);
  assign w_step_trig  = step_req & ~run_en;
  assign w_trig       = w_wrap | w_step_trig;
  assign w_drop       = w_trig & (r_gen_pend | (r_state == ST_CALC));
  assign w_accept     = w_trig & ~w_drop;

  // ---------------------------------------------------------------------------
  // Edit selection: a request arriving on the dispatch cycle replaces the buffer
  // contents directly, so back-to-back edits still retire with a single ack.
  // ---------------------------------------------------------------------------
  assign w_sel_op    = edit_req ? edit_op : r_buf_op;
  assign w_sel_x     = edit_req ? edit_x  : r_buf_x;
  assign w_sel_y     = edit_req ? edit_y  : r_buf_y;
  assign w_is_toggle = (w_sel_op == OP_TOGGLE);
  assign w_in_range  = (32'(w_sel_x) < 32'(GRID_W)) && (32'(w_sel_y) < 32'(GRID_H));
  assign w_addr      = 8'((32'(w_sel_y) * 32'(GRID_W)) + 32'(w_sel_x));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  assign w_go_calc  = (r_state == ST_IDLE) & r_gen_pend;
  assign w_go_edit  = (r_state == ST_IDLE) & ~r_gen_pend & r_edit_pend;
  // r_calc_start marks the first CALC cycle, where calc_done is not yet meaningful.
  assign w_calc_end = (r_state == ST_CALC) & ~r_calc_start & calc_done;

  always_comb begin
    // NOTE: w_state_nxt gets a default before the case so no path can infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_gen_pend) begin
          w_state_nxt = ST_CALC;
        end else if (r_edit_pend) begin
          w_state_nxt = ST_EDIT;
        end
      end
      ST_CALC: begin
        if (w_calc_end) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EDIT: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_gen_pend  <= 1'b0;
      r_edit_pend <= 1'b0;
      r_buf_op    <= '0;
      r_buf_x     <= '0;
      r_buf_y     <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (!w_run_active || w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      r_gen_pend <= w_go_calc ? 1'b0 : (r_gen_pend | w_accept);

      if (edit_req) begin
        r_buf_op <= edit_op;
        r_buf_x  <= edit_x;
        r_buf_y  <= edit_y;
      end
      r_edit_pend <= w_go_edit ? 1'b0 : (r_edit_pend | edit_req);
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_calc_start <= 1'b0;
      r_tick_led   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_op      <= '0;
      r_wr_addr    <= '0;
      r_edit_ack   <= 1'b0;
      r_edit_err   <= 1'b0;
      r_overrun    <= 1'b0;
      r_gen_count  <= '0;
    end else begin
      r_calc_start <= w_go_calc;
      r_tick_led   <= r_tick_led ^ w_go_calc;
      r_overrun    <= w_drop;

      r_edit_ack   <= w_go_edit;
      r_edit_err   <= w_go_edit & w_is_toggle & ~w_in_range;
      r_wr_en      <= w_go_edit & (~w_is_toggle | w_in_range);
      r_wr_op      <= w_go_edit ? w_sel_op : 2'd0;
      r_wr_addr    <= (w_go_edit & w_is_toggle & w_in_range) ? w_addr : 8'd0;

      // Map-wide edits restart the generation count together with the write.
      if (w_go_edit && !w_is_toggle) begin
        r_gen_count <= '0;
      end else if (w_calc_end) begin
        r_gen_count <= r_gen_count + 16'd1;
      end
    end
  end

`ifdef LIFE_GEN_LIMIT_EN
  logic r_halted;
  logic r_run_d;
  logic w_limit_hit;

  assign w_limit_hit = w_calc_end && (gen_limit != 16'd0) &&
                       ((r_gen_count + 16'd1) == gen_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
      r_run_d  <= 1'b0;
    end else begin
      r_run_d <= run_en;
      if ((r_run_d && !run_en) || (w_go_edit && !w_is_toggle)) begin
        r_halted <= 1'b0;
      end else if (w_limit_hit) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign w_halted = r_halted;
  assign halted   = r_halted;
`else
  assign w_halted = 1'b0;
`endif

  assign calc_start = r_calc_start;
  assign wr_en      = r_wr_en;
  assign wr_op      = r_wr_op;
  assign wr_addr    = r_wr_addr;
  assign edit_ack   = r_edit_ack;
  assign edit_err   = r_edit_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != ST_IDLE);
  assign gen_count  = r_gen_count;
  assign tick_led   = r_tick_led;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Directed self-checking bench for life_gen_scheduler; a background responder answers calc_start.
module tb_life_gen_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_en;
  logic        step_req;
  logic [31:0] period;
  logic        edit_req;
  logic [1:0]  edit_op;
  logic [3:0]  edit_x;
  logic [3:0]  edit_y;
  logic        calc_done;
  logic        calc_start;
  logic        wr_en;
  logic [1:0]  wr_op;
  logic [7:0]  wr_addr;
  logic        edit_ack;
  logic        edit_err;
  logic        overrun;
  logic        busy;
  logic [15:0] gen_count;
  logic        tick_led;
`ifdef LIFE_GEN_LIMIT_EN
  logic [15:0] gen_limit;
  logic        halted;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_gen  = 16'd0;
  logic        exp_tick = 1'b0;
  bit          resp_en  = 1'b1;
  int          resp_dly = 3;

  life_gen_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_en     (run_en),
    .step_req   (step_req),
    .period     (period),
    .edit_req   (edit_req),
    .edit_op    (edit_op),
    .edit_x     (edit_x),
    .edit_y     (edit_y),
    .calc_done  (calc_done),
`ifdef LIFE_GEN_LIMIT_EN
    .gen_limit  (gen_limit),
    .halted     (halted),
`endif
    .calc_start (calc_start),
    .wr_en      (wr_en),
    .wr_op      (wr_op),
    .wr_addr    (wr_addr),
    .edit_ack   (edit_ack),
    .edit_err   (edit_err),
    .overrun    (overrun),
    .busy       (busy),
    .gen_count  (gen_count),
    .tick_led   (tick_led)
  );

  always #5 clk = ~clk;

  // Datapath model: calc_done is sampled resp_dly rising edges after calc_start rises.
  initial begin
    calc_done = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && calc_start) begin
        repeat (resp_dly - 1) @(posedge clk);
        #1 calc_done = 1'b1;
        @(posedge clk);
        #1 calc_done = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic run_steps(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) step_req = 1'b1;
      @(negedge clk) step_req = 1'b0;
      repeat (7) @(negedge clk);
      exp_gen  = exp_gen + 16'd1;
      exp_tick = ~exp_tick;
    end
  endtask

  task automatic issue_edit(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                            output int ack_j, output int n_ack, output logic we_s,
                            output logic [1:0] op_s, output logic [7:0] addr_s,
                            output logic err_s, output logic busy_s, output logic [15:0] gc_s);
    ack_j = -1; n_ack = 0; we_s = 1'b0; op_s = 2'd0; addr_s = 8'd0;
    err_s = 1'b0; busy_s = 1'b0; gc_s = 16'd0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (edit_ack) begin
        n_ack++;
        if (ack_j < 0) begin
          ack_j = j; we_s = wr_en; op_s = wr_op; addr_s = wr_addr;
          err_s = edit_err; busy_s = busy; gc_s = gen_count;
        end
      end
      edit_req = (j == 0); edit_op = op; edit_x = x; edit_y = y;
    end
  endtask

  task automatic test_reset();
    logic [32:0] outs;
    repeat (3) @(negedge clk);
    outs = {calc_start, wr_en, wr_op, wr_addr, edit_ack, edit_err, overrun, busy, gen_count, tick_led};
    n_checks++;
    if (outs !== 33'd0) begin n_errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    outs = {calc_start, wr_en, wr_op, wr_addr, edit_ack, edit_err, overrun, busy, gen_count, tick_led};
    n_checks++;
    if (outs !== 33'd0) begin n_errors++; $display("FAIL idle_after_reset: got %h expected 0", outs); end
  endtask

  task automatic test_run_period();
    int starts = 0;
    int n_ovr  = 0;
    period = 5; resp_dly = 3;
    @(negedge clk) run_en = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (overrun) n_ovr++;
      if (calc_start) begin
        exp_tick = ~exp_tick;
        if (starts < 3) begin
          n_checks++;
          if (i != 6 + 5 * starts) begin
            n_errors++; $display("FAIL run_strobe_time: got %0d expected %0d", i, 6 + 5 * starts);
          end
          n_checks++;
          if (gen_count !== exp_gen + 16'(starts)) begin
            n_errors++; $display("FAIL run_gen_count: got %0d expected %0d", gen_count, exp_gen + 16'(starts));
          end
          n_checks++;
          if (tick_led !== exp_tick) begin
            n_errors++; $display("FAIL run_tick_led: got %0b expected %0b", tick_led, exp_tick);
          end
        end
        starts++;
      end
    end
    run_en = 1'b0;
    exp_gen = exp_gen + 16'd3;
    n_checks++;
    if (starts != 3) begin n_errors++; $display("FAIL run_strobe_count: got %0d expected 3", starts); end
    n_checks++;
    if (gen_count !== exp_gen) begin n_errors++; $display("FAIL run_final_count: got %0d expected %0d", gen_count, exp_gen); end
    n_checks++;
    if (n_ovr != 0) begin n_errors++; $display("FAIL run_no_overrun: got %0d expected 0", n_ovr); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_step();
    int extra = 0;
    resp_dly = 3;
    @(negedge clk) step_req = 1'b1;
    @(negedge clk) step_req = 1'b0;
    n_checks++;
    if (calc_start !== 1'b0) begin n_errors++; $display("FAIL step_early: got %0b expected 0", calc_start); end
    @(negedge clk);
    n_checks++;
    if (calc_start !== 1'b1) begin n_errors++; $display("FAIL step_latency: got %0b expected 1", calc_start); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (calc_start) extra++;
    end
    exp_gen = exp_gen + 16'd1; exp_tick = ~exp_tick;
    n_checks++;
    if (extra != 0) begin n_errors++; $display("FAIL step_single: got %0d extra expected 0", extra); end
    n_checks++;
    if (gen_count !== exp_gen) begin n_errors++; $display("FAIL step_gen_count: got %0d expected %0d", gen_count, exp_gen); end
  endtask

  task automatic test_step_collapse();
    int nc = 0;
    int no = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (calc_start) nc++;
      if (overrun) no++;
      step_req = (i < 2);
    end
    exp_gen = exp_gen + 16'd1; exp_tick = ~exp_tick;
    n_checks++;
    if (nc != 1) begin n_errors++; $display("FAIL collapse_starts: got %0d expected 1", nc); end
    n_checks++;
    if (no != 1) begin n_errors++; $display("FAIL collapse_overrun: got %0d expected 1", no); end
    n_checks++;
    if (tick_led !== exp_tick) begin n_errors++; $display("FAIL collapse_tick: got %0b expected %0b", tick_led, exp_tick); end
  endtask

  task automatic test_overrun();
    int  nc = 0;
    int  no = 0;
    bit  ok = 1'b0;
    period = 1; resp_dly = 6;
    @(negedge clk) run_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (calc_start) nc++;
      if (overrun) no++;
      if (gen_count == exp_gen + 16'd2) begin ok = 1'b1; break; end
    end
    run_en = 1'b0;
    exp_gen = exp_gen + 16'd2;
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL overrun_timeout: got %0d expected %0d", gen_count, exp_gen); end
    n_checks++;
    if (nc != 2) begin n_errors++; $display("FAIL overrun_starts: got %0d expected 2", nc); end
    n_checks++;
    if (no != 6) begin n_errors++; $display("FAIL overrun_pulses: got %0d expected 6", no); end
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL overrun_idle: got %0b expected 0", busy); end
    exp_tick = exp_tick ^ 1'b0;
  endtask

  task automatic test_edit_idle();
    logic [3:0] xs [3] = '{4'd5, 4'd15, 4'd0};
    logic [3:0] ys [3] = '{4'd1, 4'd15, 4'd0};
    logic [7:0] as [3] = '{8'd21, 8'd255, 8'd0};
    int aj, na; logic we, er, bs; logic [1:0] o; logic [7:0] a; logic [15:0] gc;
    for (int v = 0; v < 3; v++) begin
      issue_edit(2'd0, xs[v], ys[v], aj, na, we, o, a, er, bs, gc);
      n_checks++;
      if (aj != 2 || na != 1) begin n_errors++; $display("FAIL edit_latency: got %0d/%0d expected 2/1", aj, na); end
      n_checks++;
      if ({we, o, er, bs} !== 5'b1_00_0_1) begin
        n_errors++; $display("FAIL edit_ctrl: got we=%0b op=%0d err=%0b busy=%0b expected 1 0 0 1", we, o, er, bs);
      end
      n_checks++;
      if (a !== as[v]) begin n_errors++; $display("FAIL edit_addr: got %0d expected %0d", a, as[v]); end
      n_checks++;
      if (gc !== exp_gen) begin n_errors++; $display("FAIL edit_keep_count: got %0d expected %0d", gc, exp_gen); end
    end
  endtask

  task automatic test_last_wins();
    int nw = 0;
    int na = 0;
    logic [7:0] a = 8'd0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (wr_en) begin nw++; a = wr_addr; end
      if (edit_ack) na++;
      edit_req = (j < 2); edit_op = 2'd0;
      edit_x = (j == 0) ? 4'd1 : 4'd2;
      edit_y = (j == 0) ? 4'd1 : 4'd4;
    end
    n_checks++;
    if (nw != 1 || na != 1) begin n_errors++; $display("FAIL last_wins_count: got %0d/%0d expected 1/1", nw, na); end
    n_checks++;
    if (a !== 8'd66) begin n_errors++; $display("FAIL last_wins_addr: got %0d expected 66", a); end
  endtask

  task automatic test_edit_collision();
    int cj = -1;
    int wj = -1;
    int nw = 0;
    logic [7:0] a = 8'd0;
    logic [15:0] gc = 16'd0;
    logic ack = 1'b0;
    resp_dly = 3;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (calc_start && cj < 0) cj = j;
      if (wr_en) begin
        nw++;
        if (wj < 0) begin wj = j; a = wr_addr; gc = gen_count; ack = edit_ack; end
      end
      step_req = (j == 0); edit_req = (j == 0);
      edit_op = 2'd0; edit_x = 4'd3; edit_y = 4'd2;
    end
    exp_gen = exp_gen + 16'd1; exp_tick = ~exp_tick;
    n_checks++;
    if (cj != 2) begin n_errors++; $display("FAIL collide_calc_first: got %0d expected 2", cj); end
    n_checks++;
    if (wj != 6 || nw != 1) begin n_errors++; $display("FAIL collide_edit_after: got %0d/%0d expected 6/1", wj, nw); end
    n_checks++;
    if (a !== 8'd35 || ack !== 1'b1) begin n_errors++; $display("FAIL collide_addr: got %0d/%0b expected 35/1", a, ack); end
    n_checks++;
    if (gc !== exp_gen) begin n_errors++; $display("FAIL collide_gen: got %0d expected %0d", gc, exp_gen); end
  endtask

  task automatic test_clear();
    int aj, na; logic we, er, bs; logic [1:0] o; logic [7:0] a; logic [15:0] gc;
    issue_edit(2'd1, 4'd0, 4'd0, aj, na, we, o, a, er, bs, gc);
    exp_gen = 16'd0;
    run_steps(7);
    n_checks++;
    if (gen_count !== 16'd7) begin n_errors++; $display("FAIL clear_setup: got %0d expected 7", gen_count); end
    for (int op = 1; op <= 3; op++) begin
      issue_edit(2'(op), 4'd3, 4'd2, aj, na, we, o, a, er, bs, gc);
      n_checks++;
      if ({we, o, a, er} !== {1'b1, 2'(op), 8'd0, 1'b0}) begin
        n_errors++; $display("FAIL map_op%0d_write: got we=%0b op=%0d addr=%0d err=%0b expected 1 %0d 0 0", op, we, o, a, er, op);
      end
      n_checks++;
      if (aj != 2 || gc !== 16'd0) begin n_errors++; $display("FAIL map_op%0d_count: got %0d at %0d expected 0 at 2", op, gc, aj); end
      exp_gen = 16'd0;
      run_steps(1);
    end
  endtask

  task automatic test_reset_mid_calc();
    int nbad = 0;
    resp_en = 1'b0;
    @(negedge clk) step_req = 1'b1;
    @(negedge clk) step_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({calc_start, busy} !== 2'b11) begin n_errors++; $display("FAIL mid_calc_entry: got %b expected 11", {calc_start, busy}); end
    edit_req = 1'b1; edit_op = 2'd0; edit_x = 4'd1; edit_y = 4'd1;
    @(negedge clk) edit_req = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, gen_count, tick_led} !== 18'd0) begin
      n_errors++; $display("FAIL mid_calc_reset: got busy=%0b gen=%0d tick=%0b expected 0 0 0", busy, gen_count, tick_led);
    end
    @(negedge clk) rst_n = 1'b1;
    resp_en = 1'b1; exp_gen = 16'd0; exp_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (edit_ack || wr_en || calc_start || busy) nbad++;
    end
    n_checks++;
    if (nbad != 0) begin n_errors++; $display("FAIL mid_calc_aborted: got %0d active cycles expected 0", nbad); end
  endtask

`ifdef LIFE_GEN_LIMIT_EN
  task automatic test_gen_limit();
    int aj, na; logic we, er, bs; logic [1:0] o; logic [7:0] a; logic [15:0] gc;
    int nc = 0;
    issue_edit(2'd1, 4'd0, 4'd0, aj, na, we, o, a, er, bs, gc);
    gen_limit = 16'd3; period = 4; resp_dly = 2;
    @(negedge clk) run_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (calc_start) nc++;
    end
    n_checks++;
    if (nc != 3 || halted !== 1'b1 || gen_count !== 16'd3) begin
      n_errors++; $display("FAIL limit_halt: got starts=%0d halted=%0b gen=%0d expected 3 1 3", nc, halted, gen_count);
    end
    run_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (halted !== 1'b0) begin n_errors++; $display("FAIL limit_release: got %0b expected 0", halted); end
    run_en = 1'b1; nc = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (calc_start) nc++;
    end
    n_checks++;
    if (nc != 1) begin n_errors++; $display("FAIL limit_resume: got %0d expected 1", nc); end
    run_en = 1'b0; gen_limit = 16'd0;
    repeat (10) @(negedge clk);
  endtask
`endif

  initial begin
    rst_n = 1'b0; run_en = 1'b0; step_req = 1'b0; period = 32'd5;
    edit_req = 1'b0; edit_op = 2'd0; edit_x = 4'd0; edit_y = 4'd0;
`ifdef LIFE_GEN_LIMIT_EN
    gen_limit = 16'd0;
`endif
    test_reset();
    test_run_period();
    test_step();
    test_step_collapse();
    test_overrun();
    test_edit_idle();
    test_last_wins();
    test_edit_collision();
    test_clear();
    test_reset_mid_calc();
`ifdef LIFE_GEN_LIMIT_EN
    test_gen_limit();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
